// File: rtl/keystone_mailbox_pkg.sv
// Shared mailbox geometry for the CCU responder and the eBPF VM slot.
package keystone_mailbox_pkg;
  localparam int NUM_MAILBOX_REGS = 4;
  localparam int DATA_WIDTH       = 32;
  localparam int EVT_DEPTH        = 4;
  localparam int IW               = $clog2(NUM_MAILBOX_REGS);
  localparam int EVT_CW           = $clog2(EVT_DEPTH) + 1;
endpackage

// File: rtl/keystone_evt_fifo.sv
// Synchronous circular FIFO with a count register; DEPTH must be a power of two.
module keystone_evt_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/keystone_mailbox_responder.sv
// CCU-side mailbox responder for one VM slot: outbound/inbound banks,
// doorbell FIFO, sticky error flags and a level interrupt.
module keystone_mailbox_responder
  import keystone_mailbox_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [IW-1:0]               vm_mailbox_out_idx_i,
  input  logic [DATA_WIDTH-1:0]       vm_mailbox_out_wdata_i,
  input  logic                        vm_mailbox_out_wen_i,
  input  logic [IW-1:0]               vm_mailbox_in_idx_i,
  output logic [DATA_WIDTH-1:0]       vm_mailbox_in_rdata_o,
  input  logic                        cpu_wr_en_i,
  input  logic [IW-1:0]               cpu_wr_idx_i,
  input  logic [DATA_WIDTH-1:0]       cpu_wr_data_i,
  input  logic                        cpu_rd_en_i,
  input  logic [IW-1:0]               cpu_rd_idx_i,
  output logic [DATA_WIDTH-1:0]       cpu_rd_data_o,
  output logic                        cpu_rd_valid_o,
  input  logic                        evt_pop_i,
  output logic [IW-1:0]               evt_idx_o,
  output logic [EVT_CW-1:0]           evt_count_o,
  input  logic                        irq_en_i,
  input  logic                        clr_sticky_i,
  output logic [NUM_MAILBOX_REGS-1:0] out_full_o,
  output logic [NUM_MAILBOX_REGS-1:0] overrun_o,
  output logic                        evt_overflow_o,
  output logic                        irq_o
);
  // CPU read handshake: a read is accepted every cycle cpu_rd_en_i is high
  // (no ready); cpu_rd_valid_o pulses exactly one cycle later with the data.
  logic [DATA_WIDTH-1:0]       out_reg [NUM_MAILBOX_REGS];
  logic [DATA_WIDTH-1:0]       in_reg  [NUM_MAILBOX_REGS];
  logic [NUM_MAILBOX_REGS-1:0] overrun_set;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        evt_drop;

  keystone_evt_fifo #(.WIDTH(IW), .DEPTH(EVT_DEPTH)) u_evt_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vm_mailbox_out_wen_i),
    .pop   (evt_pop_i),
    .din   (vm_mailbox_out_idx_i),
    .head  (evt_idx_o),
    .count (evt_count_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_drop              = vm_mailbox_out_wen_i && fifo_full && !evt_pop_i;
  assign vm_mailbox_in_rdata_o = in_reg[vm_mailbox_in_idx_i];

  // A CPU read of the same register in the same cycle consumes the old value,
  // so the overwrite is not a loss.
  always_comb begin
    overrun_set = '0;
    if (vm_mailbox_out_wen_i && out_full_o[vm_mailbox_out_idx_i] &&
        !(cpu_rd_en_i && (cpu_rd_idx_i == vm_mailbox_out_idx_i)))
      overrun_set[vm_mailbox_out_idx_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_MAILBOX_REGS; i++) begin
        out_reg[i] <= '0;
        in_reg[i]  <= '0;
      end
      cpu_rd_data_o  <= '0;
      cpu_rd_valid_o <= 1'b0;
      out_full_o     <= '0;
      overrun_o      <= '0;
      evt_overflow_o <= 1'b0;
      irq_o          <= 1'b0;
    end else begin
      cpu_rd_valid_o <= cpu_rd_en_i;
      if (cpu_rd_en_i) begin
        cpu_rd_data_o            <= out_reg[cpu_rd_idx_i];
        out_full_o[cpu_rd_idx_i] <= 1'b0;
      end
      // Placed after the read clear so a same-index write leaves the flag set.
      if (vm_mailbox_out_wen_i) begin
        out_reg[vm_mailbox_out_idx_i]    <= vm_mailbox_out_wdata_i;
        out_full_o[vm_mailbox_out_idx_i] <= 1'b1;
      end
      if (cpu_wr_en_i) in_reg[cpu_wr_idx_i] <= cpu_wr_data_i;
      overrun_o      <= (clr_sticky_i ? '0 : overrun_o) | overrun_set;
      evt_overflow_o <= (clr_sticky_i ? 1'b0 : evt_overflow_o) | evt_drop;
      irq_o          <= irq_en_i && !fifo_empty;
    end
  end
endmodule

// File: tb/tb_keystone_mailbox_responder.sv
// Directed bench for keystone_mailbox_responder: per-feature tasks with inline checks.
module tb_keystone_mailbox_responder;
  import keystone_mailbox_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [IW-1:0]               vm_mailbox_out_idx_i;
  logic [DATA_WIDTH-1:0]       vm_mailbox_out_wdata_i;
  logic                        vm_mailbox_out_wen_i;
  logic [IW-1:0]               vm_mailbox_in_idx_i;
  logic [DATA_WIDTH-1:0]       vm_mailbox_in_rdata_o;
  logic                        cpu_wr_en_i;
  logic [IW-1:0]               cpu_wr_idx_i;
  logic [DATA_WIDTH-1:0]       cpu_wr_data_i;
  logic                        cpu_rd_en_i;
  logic [IW-1:0]               cpu_rd_idx_i;
  logic [DATA_WIDTH-1:0]       cpu_rd_data_o;
  logic                        cpu_rd_valid_o;
  logic                        evt_pop_i;
  logic [IW-1:0]               evt_idx_o;
  logic [EVT_CW-1:0]           evt_count_o;
  logic                        irq_en_i;
  logic                        clr_sticky_i;
  logic [NUM_MAILBOX_REGS-1:0] out_full_o;
  logic [NUM_MAILBOX_REGS-1:0] overrun_o;
  logic                        evt_overflow_o;
  logic                        irq_o;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [IW-1:0] exp_q[$];

  keystone_mailbox_responder dut (
    .clk(clk), .reset(reset),
    .vm_mailbox_out_idx_i(vm_mailbox_out_idx_i), .vm_mailbox_out_wdata_i(vm_mailbox_out_wdata_i),
    .vm_mailbox_out_wen_i(vm_mailbox_out_wen_i), .vm_mailbox_in_idx_i(vm_mailbox_in_idx_i),
    .vm_mailbox_in_rdata_o(vm_mailbox_in_rdata_o), .cpu_wr_en_i(cpu_wr_en_i),
    .cpu_wr_idx_i(cpu_wr_idx_i), .cpu_wr_data_i(cpu_wr_data_i), .cpu_rd_en_i(cpu_rd_en_i),
    .cpu_rd_idx_i(cpu_rd_idx_i), .cpu_rd_data_o(cpu_rd_data_o), .cpu_rd_valid_o(cpu_rd_valid_o),
    .evt_pop_i(evt_pop_i), .evt_idx_o(evt_idx_o), .evt_count_o(evt_count_o),
    .irq_en_i(irq_en_i), .clr_sticky_i(clr_sticky_i), .out_full_o(out_full_o),
    .overrun_o(overrun_o), .evt_overflow_o(evt_overflow_o), .irq_o(irq_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vm_mailbox_out_wen_i = 1'b0; vm_mailbox_out_idx_i = '0; vm_mailbox_out_wdata_i = '0;
    cpu_wr_en_i = 1'b0; cpu_wr_idx_i = '0; cpu_wr_data_i = '0;
    cpu_rd_en_i = 1'b0; cpu_rd_idx_i = '0;
    evt_pop_i = 1'b0; clr_sticky_i = 1'b0;
  endtask

  task automatic vm_write(input logic [IW-1:0] idx, input logic [DATA_WIDTH-1:0] data);
    vm_mailbox_out_wen_i = 1'b1; vm_mailbox_out_idx_i = idx; vm_mailbox_out_wdata_i = data;
    tick();
    vm_mailbox_out_wen_i = 1'b0;
  endtask

  task automatic cpu_read(input logic [IW-1:0] idx);
    cpu_rd_en_i = 1'b1; cpu_rd_idx_i = idx;
    tick();
    cpu_rd_en_i = 1'b0;
  endtask

  task automatic pop_once();
    evt_pop_i = 1'b1;
    tick();
    evt_pop_i = 1'b0;
  endtask

  task automatic clear_sticky();
    clr_sticky_i = 1'b1;
    tick();
    clr_sticky_i = 1'b0;
  endtask

  task automatic drain_fifo();
    for (int i = 0; i < 2 * EVT_DEPTH && evt_count_o != '0; i++) pop_once();
    tests_run++;
    if (evt_count_o !== '0) begin tests_failed++; $display("FAIL drain_count: got %0d expected 0", evt_count_o); end
  endtask

  task automatic test_reset();
    idle_inputs();
    irq_en_i = 1'b0; vm_mailbox_in_idx_i = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if (cpu_rd_data_o !== '0 || cpu_rd_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_rd: got %h/%b expected 0/0", cpu_rd_data_o, cpu_rd_valid_o); end
    tests_run++;
    if (out_full_o !== '0 || overrun_o !== '0 || evt_overflow_o !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got %b/%b/%b expected 0", out_full_o, overrun_o, evt_overflow_o); end
    tests_run++;
    if (evt_count_o !== '0 || evt_idx_o !== '0 || irq_o !== 1'b0) begin tests_failed++; $display("FAIL reset_evt: got %0d/%0d/%b expected 0/0/0", evt_count_o, evt_idx_o, irq_o); end
    tests_run++;
    if (vm_mailbox_in_rdata_o !== '0) begin tests_failed++; $display("FAIL reset_in: got %h expected 0", vm_mailbox_in_rdata_o); end
  endtask

  task automatic test_basic();
    irq_en_i = 1'b1;
    vm_write(2'd2, 32'hDEADBEEF);
    tests_run++;
    if (out_full_o !== 4'b0100 || evt_count_o !== 3'd1 || evt_idx_o !== 2'd2) begin tests_failed++; $display("FAIL basic_push: got full=%b cnt=%0d idx=%0d expected 0100/1/2", out_full_o, evt_count_o, evt_idx_o); end
    tests_run++;
    if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL basic_irq_lat: got %b expected 0", irq_o); end
    tick();
    tests_run++;
    if (irq_o !== 1'b1) begin tests_failed++; $display("FAIL basic_irq_up: got %b expected 1", irq_o); end
    cpu_read(2'd2);
    tests_run++;
    if (cpu_rd_valid_o !== 1'b1 || cpu_rd_data_o !== 32'hDEADBEEF || out_full_o !== '0) begin tests_failed++; $display("FAIL basic_read: got v=%b d=%h full=%b expected 1/deadbeef/0000", cpu_rd_valid_o, cpu_rd_data_o, out_full_o); end
    tick();
    tests_run++;
    if (cpu_rd_valid_o !== 1'b0 || cpu_rd_data_o !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL basic_hold: got v=%b d=%h expected 0/deadbeef", cpu_rd_valid_o, cpu_rd_data_o); end
    pop_once();
    tests_run++;
    if (evt_count_o !== '0 || irq_o !== 1'b1) begin tests_failed++; $display("FAIL basic_pop: got cnt=%0d irq=%b expected 0/1", evt_count_o, irq_o); end
    tick();
    tests_run++;
    if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL basic_irq_down: got %b expected 0", irq_o); end
  endtask

  task automatic test_overrun();
    vm_write(2'd1, 32'h11);
    vm_write(2'd1, 32'h22);
    tests_run++;
    if (overrun_o !== 4'b0010) begin tests_failed++; $display("FAIL ovr_set: got %b expected 0010", overrun_o); end
    cpu_read(2'd1);
    tests_run++;
    if (cpu_rd_data_o !== 32'h22) begin tests_failed++; $display("FAIL ovr_data: got %h expected 22", cpu_rd_data_o); end
    clear_sticky();
    tests_run++;
    if (overrun_o !== '0) begin tests_failed++; $display("FAIL ovr_clear: got %b expected 0000", overrun_o); end
    vm_write(2'd1, 32'h33);
    clr_sticky_i = 1'b1;
    vm_write(2'd1, 32'h44);
    clr_sticky_i = 1'b0;
    tests_run++;
    if (overrun_o !== 4'b0010) begin tests_failed++; $display("FAIL ovr_set_wins: got %b expected 0010", overrun_o); end
    clear_sticky();
    cpu_read(2'd1);
    tests_run++;
    if (cpu_rd_data_o !== 32'h44 || overrun_o !== '0 || evt_overflow_o !== 1'b0) begin tests_failed++; $display("FAIL ovr_final: got d=%h ovr=%b of=%b expected 44/0000/0", cpu_rd_data_o, overrun_o, evt_overflow_o); end
    drain_fifo();
  endtask

  task automatic test_same_cycle();
    vm_write(2'd3, 32'h4);
    cpu_rd_en_i = 1'b1; cpu_rd_idx_i = 2'd3;
    vm_write(2'd3, 32'h5);
    cpu_rd_en_i = 1'b0;
    tests_run++;
    if (cpu_rd_data_o !== 32'h4 || out_full_o[3] !== 1'b1 || overrun_o[3] !== 1'b0) begin tests_failed++; $display("FAIL same_cycle: got d=%h full3=%b ovr3=%b expected 4/1/0", cpu_rd_data_o, out_full_o[3], overrun_o[3]); end
    cpu_read(2'd3);
    tests_run++;
    if (cpu_rd_data_o !== 32'h5 || out_full_o[3] !== 1'b0) begin tests_failed++; $display("FAIL same_cycle_second: got d=%h full3=%b expected 5/0", cpu_rd_data_o, out_full_o[3]); end
    drain_fifo();
  endtask

  task automatic check_pops(input string name);
    for (int i = 0; i < EVT_DEPTH; i++) begin
      logic [IW-1:0] exp;
      exp = exp_q.pop_front();
      tests_run++;
      if (evt_idx_o !== exp) begin tests_failed++; $display("FAIL %s_head%0d: got %0d expected %0d", name, i, evt_idx_o, exp); end
      pop_once();
    end
  endtask

  task automatic test_fifo_overflow();
    logic [IW-1:0] seq [5];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    clear_sticky();
    for (int i = 0; i < 5; i++) begin
      if (i < EVT_DEPTH) exp_q.push_back(seq[i]);
      vm_write(seq[i], 32'h100 + i);
    end
    tests_run++;
    if (evt_count_o !== 3'd4 || evt_overflow_o !== 1'b1) begin tests_failed++; $display("FAIL fifo_full: got cnt=%0d of=%b expected 4/1", evt_count_o, evt_overflow_o); end
    check_pops("fifo");
    tests_run++;
    if (evt_count_o !== '0 || evt_idx_o !== '0) begin tests_failed++; $display("FAIL fifo_empty: got cnt=%0d idx=%0d expected 0/0", evt_count_o, evt_idx_o); end
    pop_once();
    tests_run++;
    if (evt_count_o !== '0) begin tests_failed++; $display("FAIL fifo_underflow: got %0d expected 0", evt_count_o); end
    clear_sticky();
    for (int i = 0; i < 4; i++) vm_write(seq[i], 32'h200 + i);
    evt_pop_i = 1'b1;
    vm_write(seq[4], 32'h204);
    evt_pop_i = 1'b0;
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    tests_run++;
    if (evt_count_o !== 3'd4 || evt_overflow_o !== 1'b0) begin tests_failed++; $display("FAIL fifo_push_pop_full: got cnt=%0d of=%b expected 4/0", evt_count_o, evt_overflow_o); end
    check_pops("fifo_pp");
    tests_run++;
    if (evt_count_o !== '0) begin tests_failed++; $display("FAIL fifo_pp_empty: got %0d expected 0", evt_count_o); end
    evt_pop_i = 1'b1;
    vm_write(2'd2, 32'h300);
    evt_pop_i = 1'b0;
    tests_run++;
    if (evt_count_o !== 3'd1 || evt_idx_o !== 2'd2) begin tests_failed++; $display("FAIL fifo_push_pop_empty: got cnt=%0d idx=%0d expected 1/2", evt_count_o, evt_idx_o); end
  endtask

  task automatic test_inbound();
    vm_mailbox_in_idx_i = 2'd0;
    cpu_wr_en_i = 1'b1; cpu_wr_idx_i = 2'd0; cpu_wr_data_i = 32'hCAFE;
    #1;
    tests_run++;
    if (vm_mailbox_in_rdata_o !== '0) begin tests_failed++; $display("FAIL in_before: got %h expected 0", vm_mailbox_in_rdata_o); end
    tick();
    cpu_wr_idx_i = 2'd3; cpu_wr_data_i = 32'h1234;
    tick();
    cpu_wr_en_i = 1'b0;
    tests_run++;
    if (vm_mailbox_in_rdata_o !== 32'hCAFE) begin tests_failed++; $display("FAIL in_idx0: got %h expected cafe", vm_mailbox_in_rdata_o); end
    vm_mailbox_in_idx_i = 2'd3;
    #1;
    tests_run++;
    if (vm_mailbox_in_rdata_o !== 32'h1234) begin tests_failed++; $display("FAIL in_idx3: got %h expected 1234", vm_mailbox_in_rdata_o); end
    vm_mailbox_in_idx_i = 2'd0;
  endtask

  task automatic test_reset_mid();
    vm_write(2'd1, 32'hA1);
    vm_write(2'd1, 32'hA2);
    tick();
    tests_run++;
    if (evt_count_o !== 3'd3 || irq_o !== 1'b1) begin tests_failed++; $display("FAIL mid_pre: got cnt=%0d irq=%b expected 3/1", evt_count_o, irq_o); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (evt_count_o !== '0 || evt_idx_o !== '0 || irq_o !== 1'b0) begin tests_failed++; $display("FAIL mid_evt: got cnt=%0d idx=%0d irq=%b expected 0/0/0", evt_count_o, evt_idx_o, irq_o); end
    tests_run++;
    if (out_full_o !== '0 || overrun_o !== '0 || evt_overflow_o !== 1'b0 || cpu_rd_data_o !== '0) begin tests_failed++; $display("FAIL mid_flags: got full=%b ovr=%b of=%b d=%h expected 0", out_full_o, overrun_o, evt_overflow_o, cpu_rd_data_o); end
    tests_run++;
    if (vm_mailbox_in_rdata_o !== '0) begin tests_failed++; $display("FAIL mid_in: got %h expected 0", vm_mailbox_in_rdata_o); end
    tick();
    tests_run++;
    if (irq_o !== 1'b0 || evt_count_o !== '0) begin tests_failed++; $display("FAIL mid_after: got irq=%b cnt=%0d expected 0/0", irq_o, evt_count_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_same_cycle();
    test_fifo_overflow();
    test_inbound();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/keystone_mailbox_responder.md
Name: keystone_mailbox_responder

Overview:
CCU-side responder for one eBPF VM slot's mailbox interface. It is the other end of the slot's vm_mailbox_out_* and vm_mailbox_in_* ports. It holds an outbound bank (VM to CPU) and an inbound bank (CPU to VM), and queues VM doorbell events in a small FIFO. It presents a simple register-access port to the CCU's AXI-Lite decode logic and raises a level interrupt for the CCU interrupt aggregator. The CCU instantiates one per slot (NUM_VM_SLOTS = 8).

Parameters:
NUM_MAILBOX_REGS, 4, registers per bank; power of two, at least 2
DATA_WIDTH, 32, mailbox register width
EVT_DEPTH, 4, doorbell FIFO depth; power of two, at least 2

Ports:
clk  in  1  single clock; all logic is on the rising edge
reset  in  1  synchronous, active-high
vm_mailbox_out_idx_i  in  IW  VM write index; IW = $clog2(NUM_MAILBOX_REGS)
vm_mailbox_out_wdata_i  in  DATA_WIDTH  VM write data
vm_mailbox_out_wen_i  in  1  VM write strobe, one write per cycle
vm_mailbox_in_idx_i  in  IW  VM read index
vm_mailbox_in_rdata_o  out  DATA_WIDTH  inbound register data, combinational
cpu_wr_en_i  in  1  CPU writes the inbound bank
cpu_wr_idx_i  in  IW  CPU write index
cpu_wr_data_i  in  DATA_WIDTH  CPU write data
cpu_rd_en_i  in  1  CPU reads the outbound bank
cpu_rd_idx_i  in  IW  CPU read index
cpu_rd_data_o  out  DATA_WIDTH  registered read data
cpu_rd_valid_o  out  1  one-cycle pulse, one cycle after cpu_rd_en_i
evt_pop_i  in  1  pop the head of the doorbell FIFO
evt_idx_o  out  IW  head entry (the index the VM wrote); 0 when empty
evt_count_o  out  $clog2(EVT_DEPTH)+1  FIFO occupancy
irq_en_i  in  1  interrupt enable
clr_sticky_i  in  1  clears overrun_o and evt_overflow_o
out_full_o  out  NUM_MAILBOX_REGS  per-register unread flag, outbound bank
overrun_o  out  NUM_MAILBOX_REGS  sticky: VM overwrote an unread register
evt_overflow_o  out  1  sticky: a push was dropped because the FIFO was full
irq_o  out  1  registered; equals irq_en_i AND FIFO not empty

Behaviour:
- Reset (synchronous): all registers in both banks go to 0. cpu_rd_data_o, cpu_rd_valid_o, out_full_o, overrun_o, evt_overflow_o, evt_count_o, evt_idx_o and irq_o are 0. FIFO pointers are 0. A reset asserted mid-operation discards all pending state; no event survives it.
- VM write (wen=1):
  - Next edge: out_reg[idx] <= wdata and out_full[idx] <= 1.
  - If out_full[idx] was already 1 and the same cycle has no CPU read of that idx, overrun[idx] <= 1.
  - Every VM write also pushes idx into the doorbell FIFO.
- CPU read (rd_en=1):
  - Next cycle: cpu_rd_data_o = out_reg[idx] as sampled at the request edge, and cpu_rd_valid_o = 1.
  - out_full[idx] <= 0.
  - cpu_rd_data_o holds its value until the next read.
  - Reads are always accepted; no backpressure.
- Same-cycle VM write and CPU read, same idx:
  - The CPU receives the old data.
  - The new data is stored and out_full[idx] stays 1.
  - No overrun is flagged.
- CPU write (wr_en=1): next edge, in_reg[idx] <= data.
- vm_mailbox_in_rdata_o = in_reg[vm_mailbox_in_idx_i], combinational. A CPU write becomes visible to the VM on the cycle after the write edge.
- Doorbell FIFO:
  - Circular buffer with wrapping read and write pointers and a count register.
  - Push when count < EVT_DEPTH.
  - Push while full and with no pop in the same cycle: the entry is dropped and evt_overflow <= 1.
  - Pop while empty is ignored; count does not underflow.
  - Simultaneous push and pop while full: both take effect, count is unchanged, no overflow.
  - Simultaneous push and pop while empty: only the push takes effect, count becomes 1.
  - evt_idx_o is the entry at the read pointer when count > 0, otherwise 0.
- Sticky clear: clr_sticky_i clears overrun and evt_overflow on the next edge. A new overrun or overflow event in the same cycle wins (set has priority over clear).
- Interrupt: irq_o is registered, so it follows the FIFO state with one cycle of latency.
- Index arithmetic is IW bits unsigned. No out-of-range indices are possible.

Decomposition:
- Shared package keystone_mailbox_pkg: NUM_MAILBOX_REGS = 4, DATA_WIDTH = 32, EVT_DEPTH = 4, and the derived IW. The CCU and the VM slot use the same package.
- One sub-module: keystone_evt_fifo, a synchronous FIFO parameterised by width and depth, exposing push, pop, head, count, full and empty.

Test Plan:
- Reset then idle: all outputs are 0 and irq_o = 0.
- With irq_en = 1, VM writes idx2 = 0xDEADBEEF:
  - Next cycle: out_full = 4'b0100 and evt_count = 1.
  - One cycle later: irq_o = 1.
  - CPU reads idx2: cpu_rd_valid pulses with 0xDEADBEEF, out_full = 0.
  - Pop the FIFO: irq_o drops on the following cycle.
- VM writes idx1 twice (0x11, then 0x22) with no CPU read between them: overrun = 4'b0010 and the CPU reads 0x22. Asserting clr_sticky clears overrun to 0.
- Same-cycle VM write of idx3 = 0x5 and CPU read of idx3 with old value 0x4: the CPU gets 0x4, out_full[3] stays 1, no overrun. A second read returns 0x5.
- Five VM writes (idx 0, 1, 2, 3, 0) with no pops:
  - evt_count = 4 and evt_overflow = 1.
  - Popping four times yields idx 0, 1, 2, 3.
  - One further pop while empty leaves count at 0.
  - Repeat with pop asserted on the 5th push cycle: no overflow.
- CPU writes inbound idx0 = 0xCAFE while the VM holds in_idx = 0: rdata reads 0xCAFE on the cycle after the write edge. Assert reset mid-FIFO: all state returns to 0 on the next edge.
